// File: rtl/hls_macc_launcher.sv
// hls_macc_launcher: control and collection wrapper around the MACC core.
// Accepts one operand frame over valid/ready, holds the operands on core_i*,
// runs the core's ap_ctrl_hs start/ready/done protocol, captures o1/o2 on their
// vld strobes, keeps modulo-2^DW running sums of both results, and offers each
// result frame downstream over valid/ready. A watchdog abandons a frame whose
// core never completes (e.g. a core locked with the wrong key).
//
// Ports
//   ap_clk, ap_rst                 clock, synchronous active-high reset
//   in_valid/in_ready, in_i*       operand frame handshake and payload
//   core_i*, core_start            registered operands and ap_start to the core
//   core_done/ready/idle           ap_ctrl_hs status from the core (idle unused)
//   core_o1/o2, core_o*_vld        core results and their strobes
//   res_valid/res_ready, res_o*    result frame handshake and payload
//   acc_o1/o2, acc_clr             running result sums and their clear
//   frame_cnt                      completed (handed-off) frames, wraps
//   err, err_clr                   sticky timeout / missing-vld flag and clear
module hls_macc_launcher #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned DW             = 32
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_i1,
  input  logic [DW-1:0] in_i2,
  input  logic [DW-1:0] in_i3,
  input  logic [DW-1:0] in_i4,
  input  logic [DW-1:0] in_i6,
  output logic [DW-1:0] core_i1,
  output logic [DW-1:0] core_i2,
  output logic [DW-1:0] core_i3,
  output logic [DW-1:0] core_i4,
  output logic [DW-1:0] core_i6,
  output logic          core_start,
  input  logic          core_done,
  input  logic          core_ready,
  input  logic          core_idle,
  input  logic [DW-1:0] core_o1,
  input  logic [DW-1:0] core_o2,
  input  logic          core_o1_vld,
  input  logic          core_o2_vld,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_o1,
  output logic [DW-1:0] res_o2,
  output logic [DW-1:0] acc_o1,
  output logic [DW-1:0] acc_o2,
  input  logic          acc_clr,
  output logic [15:0]   frame_cnt,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned WD_W  = 17;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_OUT    = 2'd2
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wdog;
  logic            ready_seen;

  logic accept_c;
  logic finish_c;
  logic timeout_c;
  logic miss_c;
  logic unused_c;

  // core_idle is status only; the FSM tracks the core through start/ready/done
  assign unused_c = core_idle;

  // Frame events. A core that raised ap_ready earlier may still signal done later.
  // Done beats a same-cycle timeout. wdog+1 is the number of LAUNCH cycles
  // including the current one, so the frame gets exactly TIMEOUT_CYCLES cycles.
  always_comb begin
    accept_c  = 1'b0;
    finish_c  = 1'b0;
    timeout_c = 1'b0;
    miss_c    = 1'b0;
    accept_c  = (state == ST_IDLE) && in_ready && in_valid;
    finish_c  = (state == ST_LAUNCH) && core_done && (core_ready || ready_seen);
    timeout_c = (state == ST_LAUNCH) && !finish_c &&
                ((wdog + WD_W'(1)) == WD_W'(TIMEOUT_CYCLES));
    miss_c    = finish_c && !(core_o1_vld && core_o2_vld);
  end

  // Frame FSM with registered handshake, operand and result outputs
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      core_start <= 1'b0;
      res_valid  <= 1'b0;
      wdog       <= '0;
      ready_seen <= 1'b0;
      frame_cnt  <= '0;
      core_i1    <= '0;
      core_i2    <= '0;
      core_i3    <= '0;
      core_i4    <= '0;
      core_i6    <= '0;
      res_o1     <= '0;
      res_o2     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            core_i1    <= in_i1;
            core_i2    <= in_i2;
            core_i3    <= in_i3;
            core_i4    <= in_i4;
            core_i6    <= in_i6;
            in_ready   <= 1'b0;
            core_start <= 1'b1;
            wdog       <= '0;
            ready_seen <= 1'b0;
            state      <= ST_LAUNCH;
          end else begin
            in_ready <= 1'b1;
          end
        end

        ST_LAUNCH: begin
          wdog <= wdog + WD_W'(1);
          // ap_ctrl_hs: start stays high until ready is sampled
          if (core_ready) begin
            core_start <= 1'b0;
            ready_seen <= 1'b1;
          end
          if (finish_c) begin
            if (core_o1_vld) res_o1 <= core_o1;
            if (core_o2_vld) res_o2 <= core_o2;
            core_start <= 1'b0;
            res_valid  <= 1'b1;
            state      <= ST_OUT;
          end else if (timeout_c) begin
            core_start <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            frame_cnt <= frame_cnt + CNT_W'(1);
            state     <= ST_IDLE;
          end
        end

        default: begin
          core_start <= 1'b0;
          res_valid  <= 1'b0;
          in_ready   <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Running sums; a clear overrides a same-cycle add. Missing results are not summed.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || acc_clr) begin
      acc_o1 <= '0;
      acc_o2 <= '0;
    end else if (finish_c) begin
      if (core_o1_vld) acc_o1 <= acc_o1 + core_o1;
      if (core_o2_vld) acc_o2 <= acc_o2 + core_o2;
    end
  end

  // Sticky error; a same-cycle set beats the clear
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      err <= 1'b0;
    end else if (timeout_c || miss_c) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hls_macc_launcher.sv
// Self-checking bench for hls_macc_launcher: a nominal-latency core model,
// randomized operand/result frames and a frame-level scoreboard.
module tb_hls_macc_launcher;

  logic        ap_clk;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_i1, in_i2, in_i3, in_i4, in_i6;
  logic [31:0] core_i1, core_i2, core_i3, core_i4, core_i6;
  logic        core_start;
  logic        core_done, core_ready, core_idle;
  logic [31:0] core_o1, core_o2;
  logic        core_o1_vld, core_o2_vld;
  logic        res_valid, res_ready;
  logic [31:0] res_o1, res_o2, acc_o1, acc_o2;
  logic        acc_clr;
  logic [15:0] frame_cnt;
  logic        err, err_clr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard state (frame-level expectations)
  logic [31:0] m_acc1, m_acc2, m_res1, m_res2;
  logic [15:0] m_cnt;
  logic        m_err;

  // Core model controls
  logic [31:0] m_o1, m_o2;
  bit          hung;
  bit          miss2;
  logic [1:0]  ph;

  hls_macc_launcher #(.TIMEOUT_CYCLES(16), .DW(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_i1(in_i1), .in_i2(in_i2), .in_i3(in_i3), .in_i4(in_i4), .in_i6(in_i6),
    .core_i1(core_i1), .core_i2(core_i2), .core_i3(core_i3), .core_i4(core_i4),
    .core_i6(core_i6), .core_start(core_start),
    .core_done(core_done), .core_ready(core_ready), .core_idle(core_idle),
    .core_o1(core_o1), .core_o2(core_o2),
    .core_o1_vld(core_o1_vld), .core_o2_vld(core_o2_vld),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_o1(res_o1), .res_o2(res_o2),
    .acc_o1(acc_o1), .acc_o2(acc_o2), .acc_clr(acc_clr),
    .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Nominal core: samples start, then presents done/ready/vld three cycles later
  assign core_o1   = m_o1;
  assign core_o2   = m_o2;
  assign core_idle = (ph == 2'd0);
  always @(posedge ap_clk) begin
    core_done   <= 1'b0;
    core_ready  <= 1'b0;
    core_o1_vld <= 1'b0;
    core_o2_vld <= 1'b0;
    if (ap_rst) ph <= 2'd0;
    else begin
      case (ph)
        2'd0: if (core_start && !hung) ph <= 2'd1;
        2'd1: ph <= 2'd2;
        2'd2: begin
          ph          <= 2'd3;
          core_done   <= 1'b1;
          core_ready  <= 1'b1;
          core_o1_vld <= 1'b1;
          core_o2_vld <= !miss2;
        end
        default: ph <= 2'd0;
      endcase
    end
  end

  task automatic model_reset();
    m_acc1 = '0; m_acc2 = '0; m_res1 = '0; m_res2 = '0; m_cnt = '0; m_err = 1'b0;
  endtask

  // One frame end to end; returns its accept edge
  task automatic run_frame(input logic [31:0] o1, input logic [31:0] o2, input int hold,
                           input bit miss, input bit clr, output int t_acc);
    logic [31:0] a1, a2, a3, a4, a6;
    int k, bad, first_rv, t;
    bit done;
    a1 = $urandom; a2 = $urandom; a3 = $urandom; a4 = $urandom; a6 = $urandom;
    m_o1 = o1; m_o2 = o2; miss2 = miss;
    in_i1 = a1; in_i2 = a2; in_i3 = a3; in_i4 = a4; in_i6 = a6;
    in_valid = 1'b1;
    res_ready = (hold == 0);
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(negedge ap_clk); k++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept: in_ready=%b required 1", in_ready);
      in_valid = 1'b0; t_acc = cyc; return;
    end
    t = cyc + 1;
    t_acc = t;
    m_res1 = o1;
    if (!miss) m_res2 = o2;
    if (clr) begin m_acc1 = '0; m_acc2 = '0; end
    else begin m_acc1 = m_acc1 + o1; if (!miss) m_acc2 = m_acc2 + o2; end
    m_cnt = m_cnt + 16'd1;
    if (miss) m_err = 1'b1;

    @(negedge ap_clk);
    in_valid = (hold > 0);
    if (hold > 0) begin in_i1 = ~a1; in_i2 = ~a2; in_i3 = ~a3; in_i4 = ~a4; in_i6 = ~a6; end
    checks++;
    if ({core_i1, core_i2, core_i3, core_i4, core_i6} !== {a1, a2, a3, a4, a6}) begin
      failures++;
      $display("FAIL operands: core_i1=%h core_i6=%h required %h %h", core_i1, core_i6, a1, a6);
    end
    bad = 0; first_rv = -1; done = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      if (cyc <= t + 4 && core_start !== (cyc < t + 4)) bad++;
      if (core_i1 !== a1 || core_i6 !== a6) bad++;
      if (res_valid === 1'b1 && first_rv < 0) first_rv = cyc;
      if (first_rv < 0 && res_valid !== 1'b0) bad++;
      if (first_rv >= 0) begin
        if (res_valid !== 1'b1 || res_o1 !== m_res1 || res_o2 !== m_res2 || in_ready !== 1'b0) bad++;
        if (cyc - first_rv >= hold) begin res_ready = 1'b1; in_valid = 1'b0; done = 1; end
      end
      if (clr) acc_clr = (cyc == t + 3);
      @(negedge ap_clk);
    end
    acc_clr = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;

    checks++;
    if (!done) begin failures++; $display("FAIL handshake: no result frame within budget"); end
    checks++;
    if (first_rv != t + 4) begin
      failures++; $display("FAIL res_latency: res_valid at edge %0d required %0d", first_rv, t + 4);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL frame_cycles: %0d bad cycles required 0", bad); end
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL post_handshake: res_valid=%b in_ready=%b required 0 1", res_valid, in_ready);
    end
    checks++;
    if (acc_o1 !== m_acc1 || acc_o2 !== m_acc2) begin
      failures++;
      $display("FAIL acc: acc_o1=%h acc_o2=%h required %h %h", acc_o1, acc_o2, m_acc1, m_acc2);
    end
    checks++;
    if (frame_cnt !== m_cnt) begin
      failures++; $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, m_cnt);
    end
    checks++;
    if (err !== m_err) begin failures++; $display("FAIL err: got %b required %b", err, m_err); end
  endtask

  task automatic pulse_acc_clr();
    acc_clr = 1'b1; @(negedge ap_clk); acc_clr = 1'b0;
    m_acc1 = '0; m_acc2 = '0;
    checks++;
    if (acc_o1 !== 32'd0 || acc_o2 !== 32'd0) begin
      failures++; $display("FAIL acc_clr: acc_o1=%h acc_o2=%h required 0 0", acc_o1, acc_o2);
    end
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; @(negedge ap_clk); err_clr = 1'b0;
    m_err = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_clr: err=%b required 0", err); end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    model_reset();
    checks++;
    if (in_ready !== 1'b0 || core_start !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: in_ready=%b start=%b res_valid=%b err=%b required 0 0 0 0",
               in_ready, core_start, res_valid, err);
    end
    checks++;
    if (frame_cnt !== 16'd0 || acc_o1 !== 32'd0 || acc_o2 !== 32'd0 || res_o1 !== 32'd0 ||
        res_o2 !== 32'd0 || core_i1 !== 32'd0 || core_i6 !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: cnt=%0d acc1=%h res1=%h core_i1=%h required all 0",
               frame_cnt, acc_o1, res_o1, core_i1);
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release: in_ready=%b required 1", in_ready); end
  endtask

  task automatic test_single();
    int t;
    run_frame(32'h10, 32'h20, 0, 1'b0, 1'b0, t);
    checks++;
    if (res_o1 !== 32'h10 || res_o2 !== 32'h20 || acc_o1 !== 32'h10 || acc_o2 !== 32'h20 ||
        frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single: res=%h/%h acc=%h/%h cnt=%0d required 10/20 10/20 1",
               res_o1, res_o2, acc_o1, acc_o2, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int t, prev;
    pulse_acc_clr();
    prev = 0;
    for (int i = 1; i <= 4; i++) begin
      run_frame(32'(i), $urandom, 0, 1'b0, 1'b0, t);
      if (i > 1) begin
        checks++;
        if (t - prev != 6) begin
          failures++; $display("FAIL b2b_interval: %0d cycles required 6", t - prev);
        end
      end
      prev = t;
    end
    checks++;
    if (acc_o1 !== 32'd10) begin failures++; $display("FAIL b2b_acc: acc_o1=%0d required 10", acc_o1); end
  endtask

  task automatic test_backpressure();
    int t;
    run_frame($urandom, $urandom, 10, 1'b0, 1'b0, t);
  endtask

  task automatic test_wrap_clear();
    int t;
    pulse_acc_clr();
    run_frame(32'hFFFF_FFF0, $urandom, 0, 1'b0, 1'b0, t);
    run_frame(32'h20, $urandom, 0, 1'b0, 1'b0, t);
    checks++;
    if (acc_o1 !== 32'h10) begin failures++; $display("FAIL wrap: acc_o1=%h required 00000010", acc_o1); end
    run_frame($urandom, $urandom, 0, 1'b0, 1'b1, t);
    checks++;
    if (acc_o1 !== 32'd0) begin failures++; $display("FAIL clr_capture: acc_o1=%h required 0", acc_o1); end
  endtask

  task automatic test_missing_vld();
    int t;
    run_frame($urandom, $urandom, 1, 1'b1, 1'b0, t);
    pulse_err_clr();
  endtask

  task automatic test_hung();
    int t, k, bad;
    hung = 1'b1;
    in_i1 = $urandom; in_i2 = $urandom; in_i3 = $urandom; in_i4 = $urandom; in_i6 = $urandom;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(negedge ap_clk); k++; end
    t = cyc + 1;
    @(negedge ap_clk);
    in_valid = 1'b0;
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      if (err !== 1'b0 || core_start !== 1'b1 || res_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      @(negedge ap_clk);
    end
    m_err = 1'b1;
    checks++;
    if (bad != 0 || cyc != t + 16) begin
      failures++; $display("FAIL hung_launch: %0d bad cycles required 0", bad);
    end
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1 || core_start !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL hung_timeout: err=%b in_ready=%b start=%b res_valid=%b required 1 1 0 0",
               err, in_ready, core_start, res_valid);
    end
    checks++;
    if (frame_cnt !== m_cnt) begin
      failures++; $display("FAIL hung_cnt: frame_cnt=%0d required %0d", frame_cnt, m_cnt);
    end
    hung = 1'b0;
    pulse_err_clr();
  endtask

  task automatic test_random_frames();
    int t;
    for (int i = 0; i < 6; i++) run_frame($urandom, $urandom, $urandom_range(0, 3), 1'b0, 1'b0, t);
  endtask

  task automatic test_reset_in_launch();
    int k, bad;
    in_i1 = $urandom; in_i6 = $urandom;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin @(negedge ap_clk); k++; end
    @(negedge ap_clk);
    in_valid = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    model_reset();
    checks++;
    if (core_start !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_launch_ctrl: start=%b res_valid=%b in_ready=%b err=%b required 0 0 0 0",
               core_start, res_valid, in_ready, err);
    end
    checks++;
    if (acc_o1 !== 32'd0 || acc_o2 !== 32'd0 || frame_cnt !== 16'd0 || core_i1 !== 32'd0 ||
        res_o1 !== 32'd0 || res_o2 !== 32'd0) begin
      failures++;
      $display("FAIL rst_launch_data: acc1=%h cnt=%0d core_i1=%h res1=%h required all 0",
               acc_o1, frame_cnt, core_i1, res_o1);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge ap_clk);
      if (res_valid !== 1'b0 || core_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_launch_after: %0d bad cycles, in_ready=%b required 0, 1", bad, in_ready);
    end
  endtask

  task automatic test_after_reset();
    int t;
    run_frame($urandom, $urandom, 0, 1'b0, 1'b0, t);
  endtask

  initial begin
    ap_rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1; acc_clr = 1'b0; err_clr = 1'b0;
    in_i1 = '0; in_i2 = '0; in_i3 = '0; in_i4 = '0; in_i6 = '0;
    m_o1 = '0; m_o2 = '0; hung = 1'b0; miss2 = 1'b0;
    model_reset();
    @(negedge ap_clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap_clear();
    test_missing_vld();
    test_hung();
    test_random_frames();
    test_reset_in_launch();
    test_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hls_macc_launcher.md
# hls_macc_launcher

Control and collection stage that sits directly upstream and downstream of the obfuscated MACC core. It accepts one operand frame (i1, i2, i3, i4, i6) over a valid/ready handshake, holds the operands stable and drives the core's ap_ctrl_hs start/ready protocol. It captures o1/o2 on their ap_vld strobes, keeps running 32-bit accumulators of both results, and presents each result frame downstream over a valid/ready handshake. A watchdog catches a core that never completes, for example under a wrong locking key.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in LAUNCH before the frame is abandoned; legal range 4..65535.
- DW, 32: data width of operands and results.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand frame valid.
- in_ready  out  1  launcher can accept a frame.
- in_i1, in_i2, in_i3, in_i4, in_i6  in  DW each  operand frame.
- core_i1, core_i2, core_i3, core_i4, core_i6  out  DW each  registered operands driven to the core.
- core_start  out  1  ap_start to the core.
- core_done  in  1  ap_done from the core.
- core_ready  in  1  ap_ready from the core.
- core_idle  in  1  ap_idle from the core; status only, not used by the FSM.
- core_o1, core_o2  in  DW each  core results.
- core_o1_vld, core_o2_vld  in  1 each  core result strobes.
- res_valid  out  1  result frame valid.
- res_ready  in  1  downstream accepts the result frame.
- res_o1, res_o2  out  DW each  captured results.
- acc_o1, acc_o2  out  DW each  running sums of accepted results.
- acc_clr  in  1  synchronous clear of both accumulators.
- frame_cnt  out  16  count of completed frames; wraps.
- err  out  1  sticky error flag.
- err_clr  in  1  clears err.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, register all operands into core_i* and go to LAUNCH.
  - LAUNCH: core_start=1 and the watchdog counts.
    - core_ready=1 with core_done=1: capture results and go to OUT.
    - Watchdog reaches TIMEOUT_CYCLES: set err, drop the frame, return to IDLE.
  - OUT: res_valid=1. On res_ready, go to IDLE and increment frame_cnt.
- core_start is held high until core_ready is sampled high, per ap_ctrl_hs. It deasserts the cycle after.
- Capture rules:
  - res_o1 loads core_o1 only when core_o1_vld=1; res_o2 loads core_o2 only when core_o2_vld=1.
  - If core_done=1 while either vld is 0, set err. The frame still goes to OUT, carrying stale values for the missing result.
- Accumulators:
  - acc_o1 += core_o1 and acc_o2 += core_o2 at the capture edge, modulo 2^DW, no saturation.
  - acc_clr has priority over a same-cycle add; the result is 0, not the new sample.
- err is set by a timeout or a missing vld. err_clr clears it; a same-cycle set wins over the clear.
- core_i* registers are stable from the accept edge until the next accept.
- Reset mid-frame: the frame is discarded, core_start drops immediately, and no partial result is emitted.

## Timing
- Reset values:
  - FSM in IDLE; in_ready=0 while ap_rst=1 and 1 in the first cycle after release.
  - core_start=0, res_valid=0, err=0, frame_cnt=0, acc_o1=acc_o2=0, res_o1=res_o2=0, core_i*=0.
- Nominal core: start is sampled in state1 at cycle T+1, and done/ready/vld all arrive in state4 at T+4.
- Frame accepted at edge T:
  - core_start is high during T+1..T+4.
  - Results are captured at the T+4 edge.
  - res_valid=1 from T+5.
- With res_ready tied high, the next frame is accepted at T+6, giving a 6-cycle initiation interval.
- res_valid and res_o* hold stable until the handshake completes.
- Watchdog:
  - Counter clears on entry to LAUNCH and increments each LAUNCH cycle.
  - Timeout fires on the edge where the count equals TIMEOUT_CYCLES.
  - If core_done arrives in the same cycle as the timeout, done wins: capture the results, no error.

## Test plan
- Single frame: core model returns o1=0x10, o2=0x20 three cycles after start is sampled.
  - Expect res_valid at T+5 with res_o1=0x10, res_o2=0x20.
  - Expect acc_o1=0x10, acc_o2=0x20, frame_cnt=1.
- Back-to-back frames with res_ready=1: four frames with o1=1,2,3,4.
  - Expect accepts 6 cycles apart and acc_o1=10.
- Backpressure: hold res_ready=0 for 10 cycles.
  - Expect res_valid and res_o* stable, in_ready=0 throughout, and no second frame accepted.
- Wrap and clear:
  - With acc_o1=0xFFFFFFF0, a frame with o1=0x20 gives acc_o1=0x10.
  - acc_clr asserted in the capture cycle gives acc_o1=0.
- Hung core: core_done never asserts with TIMEOUT_CYCLES=16.
  - Expect err=1 after 16 LAUNCH cycles, then IDLE and in_ready=1, with no res_valid.
  - err_clr then clears err.
- Reset in LAUNCH: assert ap_rst at T+2.
  - Expect core_start=0 on the next cycle and all outputs at their reset values, with no res_valid.
